// File: rtl/instruction_queue.sv
// Circular instruction FIFO between fetch and decoder.
// Holds {inst, pc} pairs, presents the oldest entry, flushable by decoder or ROB.
module instruction_queue #(
   parameter int IDWidth      = 32,
   parameter int AddressWidth = 32,
   parameter int QueueSizeLog = 3
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    if_instqueue_en_in,
   input  logic [IDWidth-1:0]      if_instqueue_inst_in,
   input  logic [AddressWidth-1:0] if_instqueue_pc_in,
   output logic                    instqueue_if_full_out,
   input  logic                    dispatcher_instqueue_stall_in,
   output logic                    instqueue_decoder_en_out,
   output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
   output logic [AddressWidth-1:0] instqueue_decoder_pc_out,
   input  logic                    decoder_instqueue_rst_in,
   input  logic                    rob_instqueue_rst_in
);

   localparam int unsigned Depth = 1 << QueueSizeLog;
   localparam logic [QueueSizeLog:0] CountMax  = {1'b1, {QueueSizeLog{1'b0}}};
   localparam logic [QueueSizeLog:0] FullMark  = CountMax - 1'b1;

   logic [IDWidth-1:0]      inst_mem_q [Depth];
   logic [AddressWidth-1:0] pc_mem_q   [Depth];

   logic [QueueSizeLog-1:0] head_q, head_d;
   logic [QueueSizeLog-1:0] tail_q, tail_d;
   logic [QueueSizeLog:0]   count_q, count_d;

   logic flush;
   logic pop;
   logic push;

   assign flush = decoder_instqueue_rst_in | rob_instqueue_rst_in;
   assign pop   = (count_q != '0) & ~dispatcher_instqueue_stall_in & ~flush & rdy_in & rst_in;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push  = if_instqueue_en_in & ((count_q < CountMax) | pop) & ~flush & rdy_in & rst_in;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (!rst_in || flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (rdy_in) begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
         inst_mem_q[tail_q] <= if_instqueue_inst_in;
         pc_mem_q[tail_q]   <= if_instqueue_pc_in;
      end
   end

   assign instqueue_decoder_en_out   = pop;
   assign instqueue_decoder_inst_out = inst_mem_q[head_q];
   assign instqueue_decoder_pc_out   = pc_mem_q[head_q];
   assign instqueue_if_full_out      = (count_q >= FullMark);

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO between instruction fetch and decoder.
- Buffers fetched instruction words with their PCs and presents the oldest entry to the decoder.
- Provides the decoder-facing half of the instqueue/decoder interface: en/inst/pc out, flush request in.
- Also flushed by the ROB on branch misprediction; throttles fetch through an almost-full flag.

Parameters:
IDWidth, 32, instruction word width
AddressWidth, 32, PC width
QueueSizeLog, 3, log2 of entry count (default 8 entries)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous reset, active-low (reset when rst_in==0 at a rising edge)
rdy_in  input  1  global ready; 0 freezes the block
if_instqueue_en_in  input  1  push strobe from fetch
if_instqueue_inst_in  input  IDWidth  instruction word to push
if_instqueue_pc_in  input  AddressWidth  PC of pushed word
instqueue_if_full_out  output  1  almost-full; fetch must not issue new requests while high
dispatcher_instqueue_stall_in  input  1  downstream cannot accept an instruction this cycle
instqueue_decoder_en_out  output  1  head entry valid and consumed this cycle
instqueue_decoder_inst_out  output  IDWidth  head instruction word
instqueue_decoder_pc_out  output  AddressWidth  head PC
decoder_instqueue_rst_in  input  1  flush request from decoder (JAL redirect)
rob_instqueue_rst_in  input  1  flush request from ROB (misprediction)

Behaviour:
- State: storage[2^QueueSizeLog] of {inst, pc}; head, tail pointers (QueueSizeLog bits, natural wrap); count (QueueSizeLog+1 bits).
- Reset (rst_in==0 at edge): head=tail=count=0. Storage contents are don't-care. Outputs after reset: en_out=0, full_out=0.
- Reset has priority over flush, and flush over rdy_in.
- Derived signals: flush = decoder_instqueue_rst_in | rob_instqueue_rst_in.
- pop = (count!=0) & ~dispatcher_instqueue_stall_in & ~flush & rdy_in & rst_in.
- instqueue_decoder_en_out = pop. Combinational from registered count and the current-cycle stall/flush inputs.
- inst_out/pc_out = storage[head]. Combinational read; undefined value when count==0; the decoder ignores it when en_out==0.
- Decoder consumes in the same cycle en_out is high. Pop takes effect at the next edge: head+1, count-1.
- push = if_instqueue_en_in & (count < 2^QueueSizeLog). At edge: storage[tail] <= {inst, pc}, tail+1, count+1.
- Push while count == 2^QueueSizeLog is dropped silently. This is a fetch protocol violation; it must not corrupt state.
- Simultaneous push and pop: both happen and count is unchanged. This is legal when full: the pop frees a slot, and the push is accepted because acceptance uses the pre-edge count only if no pop occurs. Precisely, accept when count<2^QueueSizeLog OR pop.
- Empty + push: no bypass. en_out stays 0 this cycle; the entry is first visible the next cycle (latency 1 from push to en_out).
- instqueue_if_full_out = (count >= 2^QueueSizeLog - 1), registered state, combinational compare. The one-slot margin covers fetch's one-cycle response latency.
- Flush (either source high, rdy_in=1): at the next edge head=tail=count=0. Same-cycle push and pop are both discarded; en_out is 0 in the flush cycle.
- The JAL that caused a decoder flush was consumed in the previous cycle, so discarding in the flush cycle is correct.
- rdy_in==0 (not in reset, no flush): all state holds, en_out=0, pushes ignored.
- Wrap-around: pointers wrap modulo 2^QueueSizeLog with no special handling. FIFO order is preserved across the wrap.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles with if_instqueue_en_in=1 -> en_out=0, full_out=0. After release, first push of inst 0x00000013/pc 0x0 appears with en_out=1 exactly one cycle later.
- Fill: push 8 words (pc 0x0..0x1C), stall=1 -> full_out rises after the 7th push. 9th push dropped. Release stall -> 8 pops in order, pc 0x0..0x1C, then en_out=0.
- Simultaneous: keep queue at count=3, push and pop every cycle for 20 cycles -> count stays 3, output pc sequence strictly increasing by 4, no gaps or duplicates.
- Wrap: stream 20 pushes with stall toggling every other cycle -> all 20 pcs delivered in order across two pointer wraps.
- Flush: count=5, assert decoder_instqueue_rst_in with concurrent push -> en_out=0 that cycle, count=0 next cycle. Pushed word never delivered. Repeat with rob_instqueue_rst_in -> same result.
- rdy_in: count=4, drop rdy_in for 3 cycles with push asserted -> en_out=0, no state change. Raise rdy_in -> same head pc delivered, count still 4.
